// File: rtl/wb_ctrl.sv
// wb_ctrl: integer write-back controller with a one-entry long-latency buffer and a pending-rd scoreboard
//   clk_i/rst_i            clock, asynchronous active-high reset
//   ex_reg_wr_*_i          single-cycle execute GPR result (always wins the write port)
//   ex_csr_wr_*_i          execute CSR write, registered straight through
//   lu_issue_i/rd_i        long-latency op issue, marks rd pending
//   lu_valid_i/rd_i/data_i long-latency result, lu_ready_o when the buffer is empty
//   reg1/reg2/rd_*_i       decode operands checked against the scoreboard, stall_o
//   wb_reg_wr_*_o          registered GPR write port
//   wb_csr_wr_*_o          registered CSR write port
module wb_ctrl #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      ex_reg_wr_data_i,
  input  logic                      ex_csr_wr_en_i,
  input  logic [CSR_ADDR_WIDTH-1:0] ex_csr_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      ex_csr_wr_data_i,
  input  logic                      lu_issue_i,
  input  logic [REG_ADDR_WIDTH-1:0] lu_issue_rd_i,
  input  logic                      lu_valid_i,
  output logic                      lu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] lu_rd_i,
  input  logic [CPU_WIDTH-1:0]      lu_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg1_rd_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg2_rd_adder_i,
  input  logic                      rd_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_adder_i,
  output logic                      stall_o,
  output logic                      wb_reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_reg_wr_data_o,
  output logic                      wb_csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] wb_csr_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_csr_wr_data_o
);
  localparam int DEPTH = 1 << REG_ADDR_WIDTH;
  logic                      buf_vld_q, buf_vld_d;
  logic [REG_ADDR_WIDTH-1:0] buf_rd_q, buf_rd_d;
  logic [CPU_WIDTH-1:0]      buf_data_q, buf_data_d;
  logic [DEPTH-1:0]          pending_q, pending_d;
  logic                      reg_en_q, reg_en_d;
  logic [REG_ADDR_WIDTH-1:0] reg_adder_q, reg_adder_d;
  logic [CPU_WIDTH-1:0]      reg_data_q, reg_data_d;
  logic                      csr_en_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_adder_q;
  logic [CPU_WIDTH-1:0]      csr_data_q;
  logic                      ex_win, drain, accept;
  assign lu_ready_o = !buf_vld_q;
  assign ex_win     = ex_reg_wr_en_i && |ex_reg_wr_adder_i;
  assign drain      = !ex_win && buf_vld_q;
  // rd = 0 results are acknowledged but never occupy the buffer
  assign accept     = lu_valid_i && lu_ready_o && |lu_rd_i;
  assign stall_o    = pending_q[reg1_rd_adder_i] | pending_q[reg2_rd_adder_i] |
                      (rd_wr_en_i & pending_q[rd_adder_i]);
  always_comb begin
    buf_vld_d   = accept | (buf_vld_q & !drain);
    buf_rd_d    = accept ? lu_rd_i : buf_rd_q;
    buf_data_d  = accept ? lu_data_i : buf_data_q;
    reg_en_d    = ex_win | drain;
    reg_adder_d = ex_win ? ex_reg_wr_adder_i : drain ? buf_rd_q : reg_adder_q;
    reg_data_d  = ex_win ? ex_reg_wr_data_i : drain ? buf_data_q : reg_data_q;
    pending_d   = pending_q;
    // clear before set so a same-index issue in the drain cycle keeps the bit
    if (drain) pending_d[buf_rd_q] = 1'b0;
    if (lu_issue_i) pending_d[lu_issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_vld_q   <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      pending_q   <= '0;
      reg_en_q    <= 1'b0;
      reg_adder_q <= '0;
      reg_data_q  <= '0;
      csr_en_q    <= 1'b0;
      csr_adder_q <= '0;
      csr_data_q  <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      pending_q   <= pending_d;
      reg_en_q    <= reg_en_d;
      reg_adder_q <= reg_adder_d;
      reg_data_q  <= reg_data_d;
      csr_en_q    <= ex_csr_wr_en_i;
      csr_adder_q <= ex_csr_wr_adder_i;
      csr_data_q  <= ex_csr_wr_data_i;
    end
  end
  assign wb_reg_wr_en_o    = reg_en_q;
  assign wb_reg_wr_adder_o = reg_adder_q;
  assign wb_reg_wr_data_o  = reg_data_q;
  assign wb_csr_wr_en_o    = csr_en_q;
  assign wb_csr_wr_adder_o = csr_adder_q;
  assign wb_csr_wr_data_o  = csr_data_q;
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed self-checking bench for wb_ctrl
module tb_wb_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_reg_wr_en_i = 1'b0;
  logic [4:0]  ex_reg_wr_adder_i = '0;
  logic [31:0] ex_reg_wr_data_i = '0;
  logic        ex_csr_wr_en_i = 1'b0;
  logic [11:0] ex_csr_wr_adder_i = '0;
  logic [31:0] ex_csr_wr_data_i = '0;
  logic        lu_issue_i = 1'b0;
  logic [4:0]  lu_issue_rd_i = '0;
  logic        lu_valid_i = 1'b0;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_i = '0;
  logic [31:0] lu_data_i = '0;
  logic [4:0]  reg1_rd_adder_i = '0;
  logic [4:0]  reg2_rd_adder_i = '0;
  logic        rd_wr_en_i = 1'b0;
  logic [4:0]  rd_adder_i = '0;
  logic        stall_o;
  logic        wb_reg_wr_en_o;
  logic [4:0]  wb_reg_wr_adder_o;
  logic [31:0] wb_reg_wr_data_o;
  logic        wb_csr_wr_en_o;
  logic [11:0] wb_csr_wr_adder_o;
  logic [31:0] wb_csr_wr_data_o;
  int checks = 0;
  int errors = 0;
  wb_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_reg_wr_en_i(ex_reg_wr_en_i), .ex_reg_wr_adder_i(ex_reg_wr_adder_i), .ex_reg_wr_data_i(ex_reg_wr_data_i),
    .ex_csr_wr_en_i(ex_csr_wr_en_i), .ex_csr_wr_adder_i(ex_csr_wr_adder_i), .ex_csr_wr_data_i(ex_csr_wr_data_i),
    .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
    .reg1_rd_adder_i(reg1_rd_adder_i), .reg2_rd_adder_i(reg2_rd_adder_i),
    .rd_wr_en_i(rd_wr_en_i), .rd_adder_i(rd_adder_i), .stall_o(stall_o),
    .wb_reg_wr_en_o(wb_reg_wr_en_o), .wb_reg_wr_adder_o(wb_reg_wr_adder_o), .wb_reg_wr_data_o(wb_reg_wr_data_o),
    .wb_csr_wr_en_o(wb_csr_wr_en_o), .wb_csr_wr_adder_o(wb_csr_wr_adder_o), .wb_csr_wr_data_o(wb_csr_wr_data_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_wb(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_en"}, 32'(wb_reg_wr_en_o), 32'(en));
    chk({tag, "_addr"}, 32'(wb_reg_wr_adder_o), 32'(a));
    chk({tag, "_data"}, wb_reg_wr_data_o, d);
  endtask
  initial begin
    #1;
    chk("rst_reg_en", 32'(wb_reg_wr_en_o), 0);
    chk("rst_csr_en", 32'(wb_csr_wr_en_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_ready", 32'(lu_ready_o), 1);
    tick();
    tick();
    rst_i = 1'b0;
    // execute write x3, then a dropped write to x0
    ex_reg_wr_en_i = 1'b1; ex_reg_wr_adder_i = 5'd3; ex_reg_wr_data_i = 32'h1234_5678;
    tick();
    chk_wb("ex_x3", 1'b1, 5'd3, 32'h1234_5678);
    ex_reg_wr_adder_i = 5'd0; ex_reg_wr_data_i = 32'hFFFF_FFFF;
    tick();
    chk_wb("ex_x0", 1'b0, 5'd3, 32'h1234_5678);
    ex_reg_wr_en_i = 1'b0;
    // long op to x7
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd7;
    tick();
    lu_issue_i = 1'b0; reg1_rd_adder_i = 5'd7;
    #1;
    chk("lo_stall_pend", 32'(stall_o), 1);
    lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = 32'hDEAD_BEEF;
    tick();
    lu_valid_i = 1'b0;
    #1;
    chk("lo_ready_full", 32'(lu_ready_o), 0);
    chk("lo_stall_buf", 32'(stall_o), 1);
    chk("lo_no_wb_yet", 32'(wb_reg_wr_en_o), 0);
    tick();
    chk_wb("lo_x7", 1'b1, 5'd7, 32'hDEAD_BEEF);
    chk("lo_stall_clr", 32'(stall_o), 0);
    chk("lo_ready_back", 32'(lu_ready_o), 1);
    reg1_rd_adder_i = 5'd0;
    // rd = 0 result is discarded, buffer stays empty
    lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_data_i = 32'h0BAD_0BAD;
    tick();
    lu_valid_i = 1'b0;
    #1;
    chk("x0_ready", 32'(lu_ready_o), 1);
    tick();
    chk("x0_no_wb", 32'(wb_reg_wr_en_o), 0);
    // collision: buffer holds x9 while ex writes x4 three times
    lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_data_i = 32'h9999_0009;
    tick();
    lu_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_reg_wr_en_i = 1'b1; ex_reg_wr_adder_i = 5'd4; ex_reg_wr_data_i = 32'h4400 + 32'(i);
      tick();
      chk_wb($sformatf("col_x4_%0d", i), 1'b1, 5'd4, 32'h4400 + 32'(i));
      chk($sformatf("col_ready_%0d", i), 32'(lu_ready_o), 0);
    end
    ex_reg_wr_en_i = 1'b0;
    tick();
    chk_wb("col_x9", 1'b1, 5'd9, 32'h9999_0009);
    chk("col_ready_after", 32'(lu_ready_o), 1);
    // set and clear of x6 in the same cycle
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd6;
    tick();
    lu_issue_i = 1'b0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd6; lu_data_i = 32'h6666_6666;
    tick();
    lu_valid_i = 1'b0;
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd6;
    tick();
    lu_issue_i = 1'b0; reg2_rd_adder_i = 5'd6;
    #1;
    chk_wb("sc_x6", 1'b1, 5'd6, 32'h6666_6666);
    chk("sc_stall_kept", 32'(stall_o), 1);
    // second x6 result drains alongside a CSR write
    lu_valid_i = 1'b1; lu_data_i = 32'h7777_7777;
    tick();
    lu_valid_i = 1'b0;
    ex_csr_wr_en_i = 1'b1; ex_csr_wr_adder_i = 12'h305; ex_csr_wr_data_i = 32'h8000_0000;
    tick();
    chk("csr_en", 32'(wb_csr_wr_en_o), 1);
    chk("csr_addr", 32'(wb_csr_wr_adder_o), 32'h305);
    chk("csr_data", wb_csr_wr_data_o, 32'h8000_0000);
    chk_wb("csr_drain_x6", 1'b1, 5'd6, 32'h7777_7777);
    chk("csr_stall_clr", 32'(stall_o), 0);
    ex_csr_wr_en_i = 1'b0;
    tick();
    chk("csr_en_off", 32'(wb_csr_wr_en_o), 0);
    chk("reg_en_off", 32'(wb_reg_wr_en_o), 0);
    reg2_rd_adder_i = 5'd0;
    // reset while the buffer holds x5 and pending[5] is set
    lu_issue_i = 1'b1; lu_issue_rd_i = 5'd5;
    tick();
    lu_issue_i = 1'b0;
    lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'h5555_5555;
    ex_reg_wr_en_i = 1'b1; ex_reg_wr_adder_i = 5'd4; ex_reg_wr_data_i = 32'h4444_4444;
    ex_csr_wr_en_i = 1'b1;
    reg1_rd_adder_i = 5'd5;
    tick();
    lu_valid_i = 1'b0;
    chk_wb("pre_rst", 1'b1, 5'd4, 32'h4444_4444);
    chk("pre_rst_stall", 32'(stall_o), 1);
    chk("pre_rst_ready", 32'(lu_ready_o), 0);
    #2;
    rst_i = 1'b1;
    #1;
    chk_wb("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_rst_csr_en", 32'(wb_csr_wr_en_o), 0);
    chk("mid_rst_csr_addr", 32'(wb_csr_wr_adder_o), 0);
    chk("mid_rst_csr_data", wb_csr_wr_data_o, 0);
    chk("mid_rst_stall", 32'(stall_o), 0);
    chk("mid_rst_ready", 32'(lu_ready_o), 1);
    tick();
    rst_i = 1'b0;
    ex_reg_wr_en_i = 1'b0; ex_csr_wr_en_i = 1'b0;
    tick();
    chk("post_rst_en1", 32'(wb_reg_wr_en_o), 0);
    tick();
    chk("post_rst_en2", 32'(wb_reg_wr_en_o), 0);
    chk("post_rst_stall", 32'(stall_o), 0);
    chk("post_rst_ready", 32'(lu_ready_o), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Write-back controller at the end of the integer pipeline. It produces the registered write-back buses that feed the register file, the CSR file and the operand bypass unit. Each cycle it arbitrates one GPR write port between the single-cycle execute result and a one-entry buffer holding results from the long-latency unit (divider/load), and routes CSR writes straight through. It also keeps a 32-entry pending-destination scoreboard and raises `stall_o` when decode reads or targets a register with a long-latency result still outstanding.

## Interface
Parameters:
- `CPU_WIDTH`, 32, data width
- `REG_ADDR_WIDTH`, 5, GPR address width (scoreboard depth = 2^REG_ADDR_WIDTH)
- `CSR_ADDR_WIDTH`, 12, CSR address width

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  asynchronous active-high reset
- `ex_reg_wr_en_i`  in  1  execute result valid for GPR write
- `ex_reg_wr_adder_i`  in  REG_ADDR_WIDTH  execute destination
- `ex_reg_wr_data_i`  in  CPU_WIDTH  execute data
- `ex_csr_wr_en_i`  in  1  execute CSR write
- `ex_csr_wr_adder_i`  in  CSR_ADDR_WIDTH  CSR address
- `ex_csr_wr_data_i`  in  CPU_WIDTH  CSR data
- `lu_issue_i`  in  1  long-latency op issued this cycle
- `lu_issue_rd_i`  in  REG_ADDR_WIDTH  destination of the issued op
- `lu_valid_i`  in  1  long-latency result valid
- `lu_ready_o`  out  1  buffer can accept a result
- `lu_rd_i`  in  REG_ADDR_WIDTH  result destination
- `lu_data_i`  in  CPU_WIDTH  result data
- `reg1_rd_adder_i`, `reg2_rd_adder_i`  in  REG_ADDR_WIDTH  decode source registers
- `rd_wr_en_i`  in  1  decode instruction writes a GPR
- `rd_adder_i`  in  REG_ADDR_WIDTH  decode destination
- `stall_o`  out  1  hold decode/issue
- `wb_reg_wr_en_o`  out  1  registered GPR write enable
- `wb_reg_wr_adder_o`  out  REG_ADDR_WIDTH  registered GPR address
- `wb_reg_wr_data_o`  out  CPU_WIDTH  registered GPR data
- `wb_csr_wr_en_o`  out  1  registered CSR write enable
- `wb_csr_wr_adder_o`  out  CSR_ADDR_WIDTH  registered CSR address
- `wb_csr_wr_data_o`  out  CPU_WIDTH  registered CSR data

## Operation
- **Buffer.** One entry: `buf_vld`, `buf_rd`, `buf_data`.
  - `lu_ready_o` = !`buf_vld` (combinational).
  - Accept on `lu_valid_i && lu_ready_o`.
  - A result with rd = 0 is accepted and discarded; the buffer stays empty.
- **GPR arbitration**, evaluated each cycle:
  - ex_win = `ex_reg_wr_en_i` && ex rd ≠ 0. The execute path never waits.
  - drain = !ex_win && `buf_vld`.
  - Next `wb_reg_wr_*`: the ex values if ex_win, else the buffer values if drain, else en = 0. Address and data hold their last value when en = 0.
  - On drain, `buf_vld` clears at the same edge.
  - An execute write with rd = 0 is dropped and does not block drain.
- **CSR path.** `wb_csr_wr_*` registers the `ex_csr_wr_*` inputs every cycle. It does not interact with GPR arbitration.
- **Scoreboard.** `pending[2^REG_ADDR_WIDTH]`.
  - Set `pending[lu_issue_rd_i]` on `lu_issue_i` with rd ≠ 0.
  - Clear `pending[buf_rd]` on drain.
  - If set and clear hit the same index in one cycle, set wins.
  - `pending[0]` is always 0.
- **Stall.** `stall_o` (combinational) = (`pending[reg1_rd_adder_i]`) | (`pending[reg2_rd_adder_i]`) | (`rd_wr_en_i` & `pending[rd_adder_i]`).
  - This blocks RAW hazards, plus WAW hazards against an outstanding long op.
  - Issuing to an already-pending rd therefore cannot occur; if it does, the bit simply stays set.
- **Consistency with bypass.** The pending bit clears at the same edge `wb_reg_wr_en_o` rises with that address. The bypass unit then forwards the value in the cycle decode is released.
- **Reset (`rst_i` = 1, asynchronous).** All `wb_*` outputs = 0, `buf_vld` = 0, all pending bits = 0, `stall_o` = 0.
  - `lu_ready_o` reads 1, but no accept is taken while `rst_i` is high.
  - Reset mid-buffer discards the buffered result.

## Timing
- Execute result → `wb_reg_wr_*`: 1 cycle.
- CSR write → `wb_csr_wr_*`: 1 cycle.
- Long result accepted at edge N (`buf_vld` = 1 after N) → `wb_reg_wr_en_o` after edge N+1 at the earliest. Each cycle with ex_win adds one cycle.
- `lu_ready_o` deasserts the cycle after an accept and reasserts the cycle after drain. Maximum long-unit throughput is one result per 2 cycles.
- `stall_o` reflects the pending state updated at the previous edge; there is no same-cycle issue→stall path.
- No combinational path from any `lu_*` input to `wb_*` outputs.

## Test plan
- **Reset:** assert `rst_i` mid-operation with `buf_vld` = 1 and pending[5] = 1 → all `wb_*` outputs 0, `stall_o` = 0; after release, no write of the buffered data.
- **Execute write:** ex write x3 = 0x1234_5678 → next cycle `wb_reg_wr_en_o` = 1, addr 3, data 0x12345678. An ex write to x0 → `wb_reg_wr_en_o` = 0.
- **Long op:** issue rd = 7; decode reads reg1 = 7 → `stall_o` = 1. `lu_valid_i` with rd 7, data 0xDEADBEEF, no ex traffic → write x7 = 0xDEADBEEF 2 cycles after accept; `stall_o` drops the same cycle.
- **Collision:** buffer holds x9 and ex writes x4 for 3 consecutive cycles → x4 written 3×, then x9 on the 4th cycle; `lu_ready_o` = 0 throughout.
- **Set/clear same cycle:** drain x6 while `lu_issue_i` targets x6 → pending[6] stays 1; `stall_o` remains asserted for reg2 = 6.
- **CSR:** CSR write 0x305 = 0x8000_0000 concurrent with a buffer drain → both `wb_csr_*` and `wb_reg_*` fire in the same cycle, 1 cycle later.
